mem_access_unit: RTL and testbench

//  MEM-stage consumer of the EX/MEM register outputs. Turns dm_addr/dm_data/ctrl_mem into a
//  req/ack data-memory bus transaction, formats loads and drives store byte enables.

---
 rtl/mem_pkg.sv | 51 +++++
 rtl/mem_load_align.sv | 46 ++++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: access-size encodings,
// ctrl_mem bit positions, FSM states and small decode helpers.
package mem_pkg;

  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } dmu_mode_e;

  localparam int CTRL_DMRD     = 0;
  localparam int CTRL_DMWE     = 1;
  localparam int CTRL_ANS_MUX  = 2;
  localparam int CTRL_MODE_LSB = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  // Unlisted codes fall back to a full-word access.
  function automatic dmu_mode_e decode_mode(input logic [2:0] raw);
    case (raw)
      3'b000:  return MODE_B;
      3'b001:  return MODE_H;
      3'b100:  return MODE_BU;
      3'b101:  return MODE_HU;
      default: return MODE_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input dmu_mode_e mode, input logic [1:0] lane);
    case (mode)
      MODE_H, MODE_HU: return lane[0];
      MODE_W:          return lane != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input dmu_mode_e mode, input logic [31:0] data);
    case (mode)
      MODE_B, MODE_BU: return {4{data[7:0]}};
      MODE_H, MODE_HU: return {2{data[15:0]}};
      default:         return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane selection for data-memory accesses: extracts and extends load data from
// a bus word, and produces the matching byte-enable mask for stores.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  mode,
  output logic [31:0] load_data,
  output logic [3:0]  lane_be
);

  dmu_mode_e   mode_d;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign mode_d    = decode_mode(mode);
  assign byte_lane = 8'(rdata >> {lane, 3'b000});
  assign half_lane = 16'(rdata >> {lane[1], 4'b0000});

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    load_data = rdata;
    lane_be   = 4'b1111;
    case (mode_d)
      MODE_B: begin
        load_data = {{24{byte_lane[7]}}, byte_lane};
        lane_be   = 4'b0001 << lane;
      end
      MODE_BU: begin
        load_data = {24'b0, byte_lane};
        lane_be   = 4'b0001 << lane;
      end
      MODE_H: begin
        load_data = {{16{half_lane[15]}}, half_lane};
        lane_be   = 4'b0011 << {lane[1], 1'b0};
      end
      MODE_HU: begin
        load_data = {16'b0, half_lane};
        lane_be   = 4'b0011 << {lane[1], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues one req/ack bus transaction per
// load/store, stalls the pipeline while it is in flight and presents the result.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [7:0]  ctrl_mem_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_i,
  input  logic [31:0] alu_ans_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic [31:0] mem_ans_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state;
  logic [CNT_W-1:0] timeout_cnt;
  logic [31:0]      load_q;
  logic [2:0]       mode_q;
  logic [1:0]       lane_q;
  logic             is_load_q;
  logic             flushed_q;

  logic        dmrd, dmwe, ans_mux, pending, misaligned;
  logic [2:0]  mode_raw, align_mode;
  logic [1:0]  align_lane;
  logic [31:0] load_data;
  logic [3:0]  lane_be;
  logic        unused_ctrl;

  assign dmrd        = ctrl_mem_i[CTRL_DMRD];
  assign dmwe        = ctrl_mem_i[CTRL_DMWE];
  assign ans_mux     = ctrl_mem_i[CTRL_ANS_MUX];
  assign mode_raw    = ctrl_mem_i[CTRL_MODE_LSB +: 3];
  assign unused_ctrl = ^ctrl_mem_i[7:6];
  assign pending     = (dmrd | dmwe) & ~flush_i;
  assign misaligned  = is_misaligned(decode_mode(mode_raw), dm_addr_i[1:0]);

  // IDLE uses the live inputs for the byte enables; REQ uses the captured
  // access so load formatting is immune to anything upstream moving.
  assign align_mode = (state == IDLE) ? mode_raw : mode_q;
  assign align_lane = (state == IDLE) ? dm_addr_i[1:0] : lane_q;

  mem_load_align u_align (
    .rdata     (bus_rdata_i),
    .lane      (align_lane),
    .mode      (align_mode),
    .load_data (load_data),
    .lane_be   (lane_be)
  );

  assign stall_o   = ((state == IDLE) && pending && !misaligned) || (state == REQ);
  assign mem_ans_o = ans_mux ? load_q : alu_ans_i;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      load_q      <= '0;
      timeout_cnt <= '0;
      mode_q      <= '0;
      lane_q      <= '0;
      is_load_q   <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (pending && misaligned) begin
            misalign_o <= 1'b1;
            load_q     <= '0;
          end else if (pending) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= dmwe & ~dmrd;
            bus_addr_o  <= {dm_addr_i[31:2], 2'b00};
            bus_be_o    <= lane_be;
            bus_wdata_o <= store_lanes(decode_mode(mode_raw), dm_data_i);
            mode_q      <= mode_raw;
            lane_q      <= dm_addr_i[1:0];
            is_load_q   <= dmrd;
            flushed_q   <= 1'b0;
            timeout_cnt <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus_ack_i) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            timeout_cnt <= '0;
            state       <= DONE;
            if (flushed_q || flush_i) load_q <= '0;
            else if (is_load_q)       load_q <= load_data;
          end else if (timeout_cnt == LAST_CNT) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_err_o   <= 1'b1;
            load_q      <= '0;
            timeout_cnt <= '0;
            state       <= DONE;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
            if (flush_i) flushed_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level reference model,
// per-cycle output comparison, directed corner cases and randomized accesses.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [7:0]  ctrl_mem_i;
  logic [31:0] dm_addr_i, dm_data_i, alu_ans_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o, misalign_o, bus_err_o;
  logic [31:0] mem_ans_o;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .ctrl_mem_i  (ctrl_mem_i),
    .dm_addr_i   (dm_addr_i),
    .dm_data_i   (dm_data_i),
    .alu_ans_i   (alu_ans_i),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_be_o    (bus_be_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .stall_o     (stall_o),
    .mem_ans_o   (mem_ans_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural load register plus per-cycle expectations.
  logic [31:0] m_load = '0;
  logic        mis_now = 1'b0, mis_next = 1'b0;
  logic        exp_valid = 1'b0, exp_stall, exp_req, exp_we, exp_mis, exp_err, exp_done;
  logic [31:0] exp_addr, exp_wdata, exp_ans;
  logic [3:0]  exp_be;

  int          obs_stall = 0, obs_req = 0, obs_mis = 0, obs_err = 0;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_ans;
  logic        obs_we;

  function automatic int norm_mode(input logic [2:0] m);
    if (m == 3'd0 || m == 3'd1 || m == 3'd4 || m == 3'd5) return int'(m);
    return 2;
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] m, input logic [31:0] a);
    int k;
    k = norm_mode(m);
    if (k == 1 || k == 5) return a[0];
    if (k == 2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] m, input logic [31:0] a);
    int k;
    k = norm_mode(m);
    if (k == 0 || k == 4) return 4'(1 << a[1:0]);
    if (k == 1 || k == 5) return 4'(3 << a[1:0]);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] m, input logic [31:0] d);
    int k;
    k = norm_mode(m);
    if (k == 0 || k == 4) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (k == 1 || k == 5) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] m, input logic [31:0] a,
                                           input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    int          k;
    k = norm_mode(m);
    b = r[8*a[1:0] +: 8];
    h = r[16*a[1] +: 16];
    case (k)
      0:       return 32'($signed(b));
      4:       return {24'b0, b};
      1:       return 32'($signed(h));
      5:       return {16'b0, h};
      default: return r;
    endcase
  endfunction

  // Single compare process: every cycle after reset, DUT outputs vs. model.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("stall_o",    32'(stall_o),    32'(exp_stall));
      check("bus_req_o",  32'(bus_req_o),  32'(exp_req));
      check("misalign_o", 32'(misalign_o), 32'(exp_mis));
      check("bus_err_o",  32'(bus_err_o),  32'(exp_err));
      check("mem_ans_o",  mem_ans_o,       exp_ans);
      if (exp_req) begin
        check("bus_we_o",    32'(bus_we_o), 32'(exp_we));
        check("bus_addr_o",  bus_addr_o,    exp_addr);
        check("bus_be_o",    32'(bus_be_o), 32'(exp_be));
        check("bus_wdata_o", bus_wdata_o,   exp_wdata);
      end
      if (stall_o)    obs_stall++;
      if (misalign_o) obs_mis++;
      if (bus_err_o)  obs_err++;
      if (bus_req_o) begin
        obs_req++;
        obs_be    = bus_be_o;
        obs_wdata = bus_wdata_o;
        obs_we    = bus_we_o;
      end
      if (exp_done) obs_ans = mem_ans_o;
    end
  end

  task automatic step(input logic stall_e, input logic req_e, input logic err_e, input logic done_e);
    exp_stall = stall_e;
    exp_req   = req_e;
    exp_err   = err_e;
    exp_done  = done_e;
    exp_mis   = mis_now;
    exp_ans   = ctrl_mem_i[2] ? m_load : alu_ans_i;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    mis_now  = mis_next;
    mis_next = 1'b0;
  endtask

  // One MEM-stage instruction. ack_delay = REQ cycles without ack before the ack
  // (>= TO means the slave never answers); flush_at: -1 none, 0 IDLE, k = k-th REQ cycle.
  task automatic do_access(input logic [7:0] ctrl, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] alu, input logic [31:0] rdata,
                           input int ack_delay, input int flush_at);
    int   n_req;
    logic timeout, flushed;
    ctrl_mem_i  = ctrl;
    dm_addr_i   = addr;
    dm_data_i   = data;
    alu_ans_i   = alu;
    bus_ack_i   = 1'b0;
    bus_rdata_i = $urandom;
    flush_i     = (flush_at == 0);
    if (!(ctrl[0] || ctrl[1]) || flush_at == 0) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      flush_i = 1'b0;
      return;
    end
    if (ref_misaligned(ctrl[5:3], addr)) begin
      mis_next = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      m_load = '0;
      return;
    end
    exp_we    = ctrl[1] & ~ctrl[0];
    exp_addr  = {addr[31:2], 2'b00};
    exp_be    = ref_be(ctrl[5:3], addr);
    exp_wdata = ref_wdata(ctrl[5:3], data);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    timeout = (ack_delay >= TO);
    n_req   = timeout ? TO : ack_delay + 1;
    flushed = 1'b0;
    for (int k = 1; k <= n_req; k++) begin
      flush_i     = (flush_at == k);
      flushed     = flushed | flush_i;
      bus_ack_i   = !timeout && (k == n_req);
      bus_rdata_i = bus_ack_i ? rdata : $urandom;
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    flush_i     = 1'b0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = $urandom;
    if (timeout || flushed) m_load = '0;
    else if (ctrl[0])       m_load = ref_load(ctrl[5:3], addr, rdata);
    step(1'b0, 1'b0, timeout, 1'b1);
  endtask

  initial begin
    int b_stall, b_req, b_mis, b_err;
    rst         = 1'b1;
    flush_i     = 1'b0;
    ctrl_mem_i  = 8'h04;
    dm_addr_i   = '0;
    dm_data_i   = '0;
    alu_ans_i   = 32'h1111_2222;
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req",   32'(bus_req_o),  32'd0);
    check("rst_bus_we",    32'(bus_we_o),   32'd0);
    check("rst_bus_addr",  bus_addr_o,      32'd0);
    check("rst_bus_be",    32'(bus_be_o),   32'd0);
    check("rst_bus_wdata", bus_wdata_o,     32'd0);
    check("rst_stall",     32'(stall_o),    32'd0);
    check("rst_misalign",  32'(misalign_o), 32'd0);
    check("rst_bus_err",   32'(bus_err_o),  32'd0);
    check("rst_mem_ans",   mem_ans_o,       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LW 0x100, ack on the second REQ cycle.
    b_stall = obs_stall;
    do_access(8'h15, 32'h100, 32'h0, 32'h0, 32'hDEAD_BEEF, 1, -1);
    check("lw_be",     32'(obs_be), 32'hF);
    check("lw_stall",  32'(obs_stall - b_stall), 32'd3);
    check("lw_ans",    obs_ans, 32'hDEAD_BEEF);

    // LW 0x101: misaligned, no bus traffic, load register cleared.
    b_stall = obs_stall; b_req = obs_req; b_mis = obs_mis;
    do_access(8'h15, 32'h101, 32'h0, 32'h0, 32'h0, 0, -1);
    ctrl_mem_i = 8'h04;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("mis_pulses", 32'(obs_mis - b_mis),     32'd1);
    check("mis_no_req", 32'(obs_req - b_req),     32'd0);
    check("mis_stall",  32'(obs_stall - b_stall), 32'd0);
    check("mis_ans",    obs_ans, 32'd0);

    // LB / LBU at 0x103.
    do_access(8'h05, 32'h103, 32'h0, 32'h0, 32'h80FF_0011, 0, -1);
    check("lb_be",  32'(obs_be), 32'h8);
    check("lb_ans", obs_ans, 32'hFFFF_FF80);
    do_access(8'h25, 32'h103, 32'h0, 32'h0, 32'h80FF_0011, 0, -1);
    check("lbu_ans", obs_ans, 32'h0000_0080);

    // SH 0x202.
    do_access(8'h0A, 32'h202, 32'h1234_ABCD, 32'h0000_55AA, 32'h0, 0, -1);
    check("sh_we",    32'(obs_we), 32'd1);
    check("sh_be",    32'(obs_be), 32'hC);
    check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    check("sh_ans",   obs_ans, 32'h0000_55AA);

    // Slave never answers: abort after TO request cycles.
    b_req = obs_req; b_err = obs_err;
    do_access(8'h15, 32'h400, 32'h0, 32'h0, 32'h0, 100, -1);
    check("to_req_cycles", 32'(obs_req - b_req), 32'd4);
    check("to_err_pulses", 32'(obs_err - b_err), 32'd1);
    check("to_ans",        obs_ans, 32'd0);
    do_access(8'h00, 32'h0, 32'h0, 32'h3333_4444, 32'h0, 0, -1);

    // Flush in the first REQ cycle, ack three cycles later.
    do_access(8'h15, 32'h100, 32'h0, 32'h0, 32'h0BAD_F00D, 0, -1);
    b_req = obs_req;
    do_access(8'h15, 32'h500, 32'h0, 32'h0, 32'hCAFE_F00D, 3, 1);
    check("fl_req_cycles", 32'(obs_req - b_req), 32'd4);
    check("fl_ans",        obs_ans, 32'd0);

    // Reset while in REQ: request drops on the next cycle.
    do_access(8'h15, 32'h100, 32'h0, 32'h0, 32'h7777_8888, 0, -1);
    ctrl_mem_i = 8'h15; dm_addr_i = 32'h300; dm_data_i = 32'h0;
    exp_we = 1'b0; exp_addr = 32'h300; exp_be = 4'hF; exp_wdata = 32'h0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    m_load = '0;
    ctrl_mem_i = 8'h04;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_req_ans", obs_ans, 32'd0);

    // Randomized accesses against the model.
    for (int i = 0; i < 300; i++) begin
      logic [7:0]  c;
      logic [31:0] a;
      int          r, fa;
      c = 8'($urandom);
      a = $urandom;
      r = $urandom_range(0, 9);
      if (r < 6)      a[1:0] = 2'b00;
      else if (r < 8) a[0]   = 1'b0;
      r  = $urandom_range(0, 9);
      fa = (r == 0) ? 0 : ((r == 1) ? $urandom_range(1, 4) : -1);
      do_access(c, a, $urandom, $urandom, $urandom, $urandom_range(0, 5), fa);
    end

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
